// File: rtl/nf10_axis_tx_pkt_fifo.sv
// nf10_axis_tx_pkt_fifo
//   Store-and-forward packet FIFO between the 256-to-64 width converter and
//   the 10G MAC TX interface. A packet is only offered on the master side once
//   its last beat is buffered, so the MAC never underruns mid-frame. The slave
//   side never backpressures: packets that cannot fit are dropped whole.
//
// Ports
//   axi_aclk, axi_reset        clock, asynchronous active-high reset
//   s_axis_t{data,strb,user,valid,last}, s_axis_tready
//                              input stream; tuser sampled on first beat
//   m_axis_t{data,strb,user,valid,last}, m_axis_tready
//                              output stream; tuser of head packet on every beat
//   drop_count[31:0], drop_pulse  (only with NF10_TX_FIFO_DROP_STATS_EN)
//                              saturating dropped-packet counter and a one-cycle
//                              pulse on each increment
//
// Optional feature macro: NF10_TX_FIFO_DROP_STATS_EN

module nf10_axis_tx_pkt_fifo #(
  parameter int unsigned C_AXIS_DATA_WIDTH  = 64,
  parameter int unsigned C_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned C_DEPTH_LOG2       = 9,
  parameter int unsigned C_PKTS_LOG2        = 5
) (
  input  logic                            axi_aclk,
  input  logic                            axi_reset,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic                            s_axis_tlast,
  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast
`ifdef NF10_TX_FIFO_DROP_STATS_EN
  ,
  output logic [31:0]                     drop_count,
  output logic [0:0]                      drop_pulse
`endif
);

  localparam int unsigned STRB_W  = C_AXIS_DATA_WIDTH / 8;
  localparam int unsigned ENTRY_W = C_AXIS_DATA_WIDTH + STRB_W + 1;
  localparam int unsigned DEPTH   = 1 << C_DEPTH_LOG2;
  localparam int unsigned PKTS    = 1 << C_PKTS_LOG2;

  localparam logic [C_DEPTH_LOG2:0] DATA_FULL_CNT = {1'b1, {C_DEPTH_LOG2{1'b0}}};
  localparam logic [C_PKTS_LOG2:0]  META_FULL_CNT = {1'b1, {C_PKTS_LOG2{1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_DROP
  } state_t;

  // Storage
  logic [ENTRY_W-1:0]            mem      [0:DEPTH-1];
  logic [C_AXIS_TUSER_WIDTH-1:0] meta_mem [0:PKTS-1];

  // Write side state
  state_t                        state_q, state_d;
  logic                          rdy_q;
  logic [C_DEPTH_LOG2:0]         wr_spec_q, wr_spec_d;
  logic [C_DEPTH_LOG2:0]         wr_commit_q, wr_commit_d;
  logic [C_AXIS_TUSER_WIDTH-1:0] tuser_stage_q, tuser_stage_d;
  logic [C_PKTS_LOG2:0]          meta_wr_q;

  // Read side state
  logic [C_DEPTH_LOG2:0]         rd_ptr_q;
  logic [C_PKTS_LOG2:0]          meta_rd_q;
  logic [C_PKTS_LOG2:0]          pkt_count_q, pkt_count_d;
  logic                          out_valid_q;
  logic [C_AXIS_DATA_WIDTH-1:0]  out_data_q;
  logic [STRB_W-1:0]             out_strb_q;
  logic                          out_last_q;

  // Combinational control
  logic                          accept;
  logic                          data_full;
  logic                          meta_full;
  logic                          wr_en;
  logic                          commit;
  logic [C_AXIS_TUSER_WIDTH-1:0] commit_tuser;
  logic                          rd_avail;
  logic                          rd_load;
  logic                          out_pop;
  logic                          meta_pop;
  logic [ENTRY_W-1:0]            rd_word;

  assign accept    = s_axis_tvalid & rdy_q;
  // Fullness uses rd_ptr before this cycle's read.
  assign data_full = ((wr_spec_q - rd_ptr_q) == DATA_FULL_CNT);
  assign meta_full = ((meta_wr_q - meta_rd_q) == META_FULL_CNT);

  // Input state machine next-state logic.
  always_comb begin
    state_d       = state_q;
    wr_spec_d     = wr_spec_q;
    wr_commit_d   = wr_commit_q;
    tuser_stage_d = tuser_stage_q;
    wr_en         = 1'b0;
    commit        = 1'b0;
    commit_tuser  = tuser_stage_q;
    if (accept) begin
      unique case (state_q)
        ST_IDLE: begin
          if (meta_full || data_full) begin
            // A dropped single-beat packet is already complete.
            if (!s_axis_tlast) state_d = ST_DROP;
          end else begin
            wr_en         = 1'b1;
            wr_spec_d     = wr_spec_q + 1'b1;
            tuser_stage_d = s_axis_tuser;
            if (s_axis_tlast) begin
              // Staging register is loaded on this same edge, so push tuser
              // straight from the input.
              commit       = 1'b1;
              commit_tuser = s_axis_tuser;
              wr_commit_d  = wr_spec_q + 1'b1;
            end else begin
              state_d = ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          if (data_full) begin
            wr_spec_d = wr_commit_q;
            state_d   = s_axis_tlast ? ST_IDLE : ST_DROP;
          end else begin
            wr_en     = 1'b1;
            wr_spec_d = wr_spec_q + 1'b1;
            if (s_axis_tlast) begin
              commit      = 1'b1;
              wr_commit_d = wr_spec_q + 1'b1;
              state_d     = ST_IDLE;
            end
          end
        end
        ST_DROP: begin
          if (s_axis_tlast) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Read side: only committed beats are visible; the output register refills
  // whenever it is empty or being emptied this cycle.
  assign rd_avail = (pkt_count_q != '0) && (rd_ptr_q != wr_commit_q);
  assign out_pop  = out_valid_q & m_axis_tready;
  assign rd_load  = rd_avail & (~out_valid_q | m_axis_tready);
  assign meta_pop = out_pop & out_last_q;
  assign rd_word  = mem[rd_ptr_q[C_DEPTH_LOG2-1:0]];

  always_comb begin
    pkt_count_d = pkt_count_q;
    unique case ({commit, meta_pop})
      2'b10:   pkt_count_d = pkt_count_q + 1'b1;
      2'b01:   pkt_count_d = pkt_count_q - 1'b1;
      default: pkt_count_d = pkt_count_q;
    endcase
  end

  // RAMs carry no reset; pointers define their valid contents.
  always_ff @(posedge axi_aclk) begin
    if (wr_en) begin
      mem[wr_spec_q[C_DEPTH_LOG2-1:0]] <= {s_axis_tlast, s_axis_tstrb, s_axis_tdata};
    end
    if (commit) begin
      meta_mem[meta_wr_q[C_PKTS_LOG2-1:0]] <= commit_tuser;
    end
  end

  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      state_q       <= ST_IDLE;
      rdy_q         <= 1'b0;
      wr_spec_q     <= '0;
      wr_commit_q   <= '0;
      tuser_stage_q <= '0;
      meta_wr_q     <= '0;
      meta_rd_q     <= '0;
      rd_ptr_q      <= '0;
      pkt_count_q   <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_strb_q    <= '0;
      out_last_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      rdy_q         <= 1'b1;
      wr_spec_q     <= wr_spec_d;
      wr_commit_q   <= wr_commit_d;
      tuser_stage_q <= tuser_stage_d;
      pkt_count_q   <= pkt_count_d;
      if (commit)   meta_wr_q <= meta_wr_q + 1'b1;
      if (meta_pop) meta_rd_q <= meta_rd_q + 1'b1;
      if (rd_load) begin
        rd_ptr_q    <= rd_ptr_q + 1'b1;
        out_valid_q <= 1'b1;
        out_data_q  <= rd_word[C_AXIS_DATA_WIDTH-1:0];
        out_strb_q  <= rd_word[C_AXIS_DATA_WIDTH +: STRB_W];
        out_last_q  <= rd_word[ENTRY_W-1];
      end else if (out_pop) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign s_axis_tready = rdy_q;
  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tdata  = out_data_q;
  assign m_axis_tstrb  = out_strb_q;
  assign m_axis_tlast  = out_last_q;
  // Gated so tuser reads 0 when idle and after reset (meta RAM is not reset).
  assign m_axis_tuser  = out_valid_q ? meta_mem[meta_rd_q[C_PKTS_LOG2-1:0]] : '0;

`ifdef NF10_TX_FIFO_DROP_STATS_EN
  logic        drop_evt;
  logic        drop_inc;
  logic [31:0] drop_count_q;
  logic        drop_pulse_q;

  // Drop decisions: start-of-packet refusal in IDLE, or a rewind in WRITE.
  assign drop_evt = accept &&
                    (((state_q == ST_IDLE) && (meta_full || data_full)) ||
                     ((state_q == ST_WRITE) && data_full));
  assign drop_inc = drop_evt && (drop_count_q != '1);

  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      drop_count_q <= '0;
      drop_pulse_q <= 1'b0;
    end else begin
      drop_pulse_q <= drop_inc;
      if (drop_inc) drop_count_q <= drop_count_q + 1'b1;
    end
  end

  assign drop_count = drop_count_q;
  assign drop_pulse = drop_pulse_q;
`endif

endmodule

// File: tb/tb_nf10_axis_tx_pkt_fifo.sv
module tb_nf10_axis_tx_pkt_fifo;

  localparam int unsigned MDL_DEPTH = 512;
  localparam int unsigned MDL_PKTS  = 32;

  logic         axi_aclk = 1'b0;
  logic         axi_reset = 1'b1;
  logic [63:0]  s_axis_tdata = '0;
  logic [7:0]   s_axis_tstrb = '0;
  logic [127:0] s_axis_tuser = '0;
  logic         s_axis_tvalid = 1'b0;
  logic         s_axis_tready;
  logic         s_axis_tlast = 1'b0;
  logic [63:0]  m_axis_tdata;
  logic [7:0]   m_axis_tstrb;
  logic [127:0] m_axis_tuser;
  logic         m_axis_tvalid;
  logic         m_axis_tready = 1'b0;
  logic         m_axis_tlast;
`ifdef NF10_TX_FIFO_DROP_STATS_EN
  logic [31:0]  drop_count;
  logic [0:0]   drop_pulse;
  int unsigned  pulse_cnt = 0;
`endif

  always #5 axi_aclk = ~axi_aclk;

  nf10_axis_tx_pkt_fifo #(
    .C_AXIS_DATA_WIDTH (64),
    .C_AXIS_TUSER_WIDTH(128),
    .C_DEPTH_LOG2      (9),
    .C_PKTS_LOG2       (5)
  ) dut (
    .axi_aclk     (axi_aclk),
    .axi_reset    (axi_reset),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tstrb (s_axis_tstrb),
    .s_axis_tuser (s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tlast (s_axis_tlast),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tstrb (m_axis_tstrb),
    .m_axis_tuser (m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast)
`ifdef NF10_TX_FIFO_DROP_STATS_EN
    ,
    .drop_count   (drop_count),
    .drop_pulse   (drop_pulse)
`endif
  );

  typedef struct packed {
    logic [127:0] user;
    logic         last;
    logic [7:0]   strb;
    logic [63:0]  data;
  } beat_t;

  beat_t       obs_q[$];
  beat_t       exp_q[$];
  beat_t       pkt_q[$];
  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned mdl_pkts = 0;
  int unsigned mdl_beats = 0;
  int unsigned exp_drops = 0;
  bit          send_done;

  // Output monitor: a beat seen valid&ready at the negedge transfers on the next posedge.
  always @(negedge axi_aclk) begin
    beat_t b;
    if (!axi_reset && m_axis_tvalid && m_axis_tready) begin
      b.user = m_axis_tuser;
      b.last = m_axis_tlast;
      b.strb = m_axis_tstrb;
      b.data = m_axis_tdata;
      obs_q.push_back(b);
    end
`ifdef NF10_TX_FIFO_DROP_STATS_EN
    if (axi_reset) pulse_cnt = 0;
    else if (drop_pulse == 1'b1) pulse_cnt++;
`endif
  end

  task automatic new_test();
    obs_q.delete();
    exp_q.delete();
    mdl_pkts  = 0;
    mdl_beats = 0;
  endtask

  task automatic build_pkt(input int unsigned len, input logic [127:0] user);
    beat_t b;
    pkt_q.delete();
    for (int unsigned i = 0; i < len; i++) begin
      b.user = user;
      b.data = {$urandom, $urandom};
      b.last = (i == len - 1);
      b.strb = b.last ? 8'($urandom_range(1, 255)) : 8'hff;
      pkt_q.push_back(b);
    end
  endtask

  task automatic send_beats(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      s_axis_tdata  = pkt_q[i].data;
      s_axis_tstrb  = pkt_q[i].strb;
      s_axis_tlast  = pkt_q[i].last;
      s_axis_tuser  = (i == 0) ? pkt_q[i].user : {$urandom, $urandom, $urandom, $urandom};
      s_axis_tvalid = 1'b1;
      @(posedge axi_aclk);
      #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  // Reference model: a packet is kept whole if packet slots and beat capacity
  // allow, otherwise it is dropped whole.
  task automatic send_pkt();
    int unsigned len = pkt_q.size();
    if (mdl_pkts >= MDL_PKTS || mdl_beats + len > MDL_DEPTH) begin
      exp_drops++;
    end else begin
      foreach (pkt_q[i]) exp_q.push_back(pkt_q[i]);
      mdl_pkts++;
      mdl_beats += len;
    end
    send_beats(len);
  endtask

  task automatic wait_drain(input int unsigned budget);
    int unsigned c = 0;
    while (obs_q.size() < exp_q.size() && c < budget) begin
      @(posedge axi_aclk);
      c++;
    end
    repeat (8) @(posedge axi_aclk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge axi_aclk);
    #1;
    tests++; if (s_axis_tready !== 1'b0) begin fails++; $display("FAIL reset_tready: got %0b expected 0", s_axis_tready); end
    tests++; if (m_axis_tvalid !== 1'b0) begin fails++; $display("FAIL reset_tvalid: got %0b expected 0", m_axis_tvalid); end
    tests++; if (m_axis_tdata !== 64'h0) begin fails++; $display("FAIL reset_tdata: got %h expected 0", m_axis_tdata); end
    tests++; if (m_axis_tstrb !== 8'h0) begin fails++; $display("FAIL reset_tstrb: got %h expected 0", m_axis_tstrb); end
    tests++; if (m_axis_tlast !== 1'b0) begin fails++; $display("FAIL reset_tlast: got %0b expected 0", m_axis_tlast); end
    tests++; if (m_axis_tuser !== 128'h0) begin fails++; $display("FAIL reset_tuser: got %h expected 0", m_axis_tuser); end
    @(negedge axi_aclk);
    axi_reset = 1'b0;
    #1;
    tests++; if (s_axis_tready !== 1'b0) begin fails++; $display("FAIL release_tready_early: got %0b expected 0", s_axis_tready); end
    @(posedge axi_aclk);
    #1;
    tests++; if (s_axis_tready !== 1'b1) begin fails++; $display("FAIL release_tready: got %0b expected 1", s_axis_tready); end
`ifdef NF10_TX_FIFO_DROP_STATS_EN
    tests++; if (drop_count !== 32'd0) begin fails++; $display("FAIL reset_drop_count: got %0d expected 0", drop_count); end
`endif
  endtask

  task automatic test_single_packet();
    new_test();
    m_axis_tready = 1'b1;
    build_pkt(4, 128'h0104);
    send_pkt();
    @(negedge axi_aclk);
    tests++; if (m_axis_tvalid !== 1'b0) begin fails++; $display("FAIL single_latency_early: got tvalid %0b expected 0", m_axis_tvalid); end
    for (int unsigned i = 0; i < 4; i++) begin
      @(negedge axi_aclk);
      tests++; if (m_axis_tvalid !== 1'b1) begin fails++; $display("FAIL single_b2b_cycle%0d: got tvalid %0b expected 1", i, m_axis_tvalid); end
    end
    wait_drain(50);
    tests++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL single_count: got %0d beats expected %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      tests++; if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL single_beat%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_stall();
    new_test();
    m_axis_tready = 1'b0;
    build_pkt(3, {$urandom, $urandom, $urandom, $urandom});
    fork
      send_pkt();
      for (int unsigned i = 0; i < 3; i++) begin
        @(negedge axi_aclk);
        tests++; if (m_axis_tvalid !== 1'b0) begin fails++; $display("FAIL stall_early_valid%0d: got %0b expected 0", i, m_axis_tvalid); end
      end
    join
    @(negedge axi_aclk);
    for (int unsigned i = 0; i < 4; i++) begin
      @(negedge axi_aclk);
      tests++; if (m_axis_tvalid !== 1'b1) begin fails++; $display("FAIL stall_valid%0d: got %0b expected 1", i, m_axis_tvalid); end
      tests++;
      if ({m_axis_tuser, m_axis_tlast, m_axis_tstrb, m_axis_tdata} !== exp_q[0]) begin
        fails++; $display("FAIL stall_hold%0d: got %h expected %h", i, {m_axis_tuser, m_axis_tlast, m_axis_tstrb, m_axis_tdata}, exp_q[0]);
      end
    end
    @(posedge axi_aclk);
    #1;
    m_axis_tready = 1'b1;
    wait_drain(50);
    tests++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL stall_count: got %0d beats expected %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      tests++; if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL stall_beat%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_oversize();
    int unsigned bad = 0;
    new_test();
    m_axis_tready = 1'b1;
    build_pkt(600, {$urandom, $urandom, $urandom, $urandom});
    fork
      send_pkt();
      repeat (600) begin
        @(negedge axi_aclk);
        if (s_axis_tready !== 1'b1) bad++;
      end
    join
    tests++; if (bad != 0) begin fails++; $display("FAIL oversize_tready: got %0d cycles low expected 0", bad); end
    build_pkt(2, {$urandom, $urandom, $urandom, $urandom});
    send_pkt();
    wait_drain(200);
    tests++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL oversize_count: got %0d beats expected %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      tests++; if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL oversize_beat%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
`ifdef NF10_TX_FIFO_DROP_STATS_EN
    tests++; if (drop_count !== exp_drops) begin fails++; $display("FAIL oversize_drop_count: got %0d expected %0d", drop_count, exp_drops); end
    tests++; if (pulse_cnt != exp_drops) begin fails++; $display("FAIL oversize_drop_pulse: got %0d expected %0d", pulse_cnt, exp_drops); end
`endif
  endtask

  task automatic test_meta_full();
    new_test();
    m_axis_tready = 1'b0;
    for (int unsigned i = 0; i < 33; i++) begin
      build_pkt(1, {96'h0, i});
      send_pkt();
    end
    repeat (4) @(posedge axi_aclk);
    #1;
    tests++; if (obs_q.size() != 0) begin fails++; $display("FAIL meta_stalled_out: got %0d beats expected 0", obs_q.size()); end
    m_axis_tready = 1'b1;
    wait_drain(200);
    tests++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL meta_count: got %0d beats expected %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      tests++; if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL meta_beat%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
`ifdef NF10_TX_FIFO_DROP_STATS_EN
    tests++; if (drop_count !== exp_drops) begin fails++; $display("FAIL meta_drop_count: got %0d expected %0d", drop_count, exp_drops); end
`endif
  endtask

  task automatic test_data_full();
    new_test();
    m_axis_tready = 1'b0;
    build_pkt(300, {$urandom, $urandom, $urandom, $urandom});
    send_pkt();
    build_pkt(300, {$urandom, $urandom, $urandom, $urandom});
    send_pkt();
    // A later packet lands right after the first one only if the rewind restored wr_commit.
    build_pkt(2, {$urandom, $urandom, $urandom, $urandom});
    send_pkt();
    m_axis_tready = 1'b1;
    wait_drain(1000);
    tests++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL dfull_count: got %0d beats expected %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      tests++; if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL dfull_beat%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
`ifdef NF10_TX_FIFO_DROP_STATS_EN
    tests++; if (drop_count !== exp_drops) begin fails++; $display("FAIL dfull_drop_count: got %0d expected %0d", drop_count, exp_drops); end
    tests++; if (pulse_cnt != exp_drops) begin fails++; $display("FAIL dfull_drop_pulse: got %0d expected %0d", pulse_cnt, exp_drops); end
`endif
  endtask

  task automatic test_back_to_back();
    new_test();
    send_done = 1'b0;
    fork
      begin
        for (int unsigned p = 0; p < 20; p++) begin
          build_pkt($urandom_range(1, 16), {$urandom, $urandom, $urandom, $urandom});
          send_pkt();
          repeat ($urandom_range(0, 3)) begin
            @(posedge axi_aclk);
            #1;
          end
        end
        send_done = 1'b1;
      end
      while (!send_done) begin
        m_axis_tready = 1'($urandom_range(0, 1));
        @(posedge axi_aclk);
        #1;
      end
    join
    m_axis_tready = 1'b1;
    wait_drain(1000);
    tests++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL b2b_count: got %0d beats expected %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      tests++; if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL b2b_beat%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    new_test();
    m_axis_tready = 1'b0;
    build_pkt(8, {$urandom, $urandom, $urandom, $urandom});
    send_pkt();
    repeat (2) begin @(posedge axi_aclk); #1; end
    m_axis_tready = 1'b1;
    repeat (3) begin @(posedge axi_aclk); #1; end
    m_axis_tready = 1'b0;
    tests++; if (m_axis_tvalid !== 1'b1) begin fails++; $display("FAIL rstmid_pre_valid: got %0b expected 1", m_axis_tvalid); end
    build_pkt(10, {$urandom, $urandom, $urandom, $urandom});
    send_beats(4);
    #2;
    axi_reset = 1'b1;
    #1;
    tests++; if (m_axis_tvalid !== 1'b0) begin fails++; $display("FAIL rstmid_tvalid: got %0b expected 0", m_axis_tvalid); end
    tests++; if (m_axis_tdata !== 64'h0) begin fails++; $display("FAIL rstmid_tdata: got %h expected 0", m_axis_tdata); end
    tests++; if (m_axis_tstrb !== 8'h0) begin fails++; $display("FAIL rstmid_tstrb: got %h expected 0", m_axis_tstrb); end
    tests++; if (m_axis_tlast !== 1'b0) begin fails++; $display("FAIL rstmid_tlast: got %0b expected 0", m_axis_tlast); end
    tests++; if (m_axis_tuser !== 128'h0) begin fails++; $display("FAIL rstmid_tuser: got %h expected 0", m_axis_tuser); end
    tests++; if (s_axis_tready !== 1'b0) begin fails++; $display("FAIL rstmid_s_tready: got %0b expected 0", s_axis_tready); end
    repeat (2) @(negedge axi_aclk);
    axi_reset = 1'b0;
    exp_drops = 0;
    new_test();
    @(posedge axi_aclk);
    #1;
    m_axis_tready = 1'b1;
    build_pkt(2, {$urandom, $urandom, $urandom, $urandom});
    send_pkt();
    wait_drain(50);
    tests++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL rstmid_count: got %0d beats expected %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      tests++; if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL rstmid_beat%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
`ifdef NF10_TX_FIFO_DROP_STATS_EN
    tests++; if (drop_count !== 32'd0) begin fails++; $display("FAIL rstmid_drop_count: got %0d expected 0", drop_count); end
`endif
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_stall();
    test_oversize();
    test_meta_full();
    test_data_full();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
